// File: rtl/kernel_fdtd_2d_mac_pipe.sv
// Pipelined multiply / multiply-accumulate operator for the fdtd-2d datapath.
// Input register, NUM_STAGE-2 product stages, then the dout/accumulator register; all ce-gated.
module kernel_fdtd_2d_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 20,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din_vld,
  input  logic                  din_acc,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  // ID is an instance tag only; folding it in as zero keeps it referenced.
  localparam int NP = NUM_STAGE - 2 + 0 * ID;

  logic [din0_WIDTH-1:0] r_a;
  logic [din1_WIDTH-1:0] r_b;
  logic                  r_vld1;
  logic                  r_acc1;
  logic [PW-1:0]         r_prod [NP];
  logic                  r_pvld [NP];
  logic                  r_pacc [NP];
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;

  logic                  w_sa;
  logic                  w_sb;
  logic [PW-1:0]         w_a_ext;
  logic [PW-1:0]         w_b_ext;
  logic [PW-1:0]         w_prod;
  logic [dout_WIDTH-1:0] w_fit;

  // Extending both operands to PW bits makes the low PW bits of the plain
  // product correct for both signed and unsigned operands.
  assign w_sa    = (SIGNED != 0) && r_a[din0_WIDTH-1];
  assign w_sb    = (SIGNED != 0) && r_b[din1_WIDTH-1];
  assign w_a_ext = {{din1_WIDTH{w_sa}}, r_a};
  assign w_b_ext = {{din0_WIDTH{w_sb}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  generate
    if (dout_WIDTH <= PW) begin : g_trunc
      assign w_fit = r_prod[NP-1][dout_WIDTH-1:0];
    end else begin : g_extend
      logic w_fs;
      assign w_fs  = (SIGNED != 0) && r_prod[NP-1][PW-1];
      assign w_fit = {{(dout_WIDTH-PW){w_fs}}, r_prod[NP-1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_vld1     <= 1'b0;
      r_acc1     <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        r_prod[i] <= '0;
        r_pvld[i] <= 1'b0;
        r_pacc[i] <= 1'b0;
      end
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else if (ce) begin
      r_a       <= din0;
      r_b       <= din1;
      r_vld1    <= din_vld;
      r_acc1    <= din_acc;
      r_prod[0] <= w_prod;
      r_pvld[0] <= r_vld1;
      r_pacc[0] <= r_acc1;
      for (int i = 1; i < NP; i++) begin
        r_prod[i] <= r_prod[i-1];
        r_pvld[i] <= r_pvld[i-1];
        r_pacc[i] <= r_pacc[i-1];
      end
      // Bubbles leave the accumulator untouched; the add wraps modulo 2^dout_WIDTH.
      if (r_pvld[NP-1]) begin
        r_dout <= r_pacc[NP-1] ? (r_dout + w_fit) : w_fit;
      end
      r_dout_vld <= r_pvld[NP-1];
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_kernel_fdtd_2d_mac_pipe.sv
// Scoreboard bench: two instances (unsigned NUM_STAGE=3/20-bit, signed NUM_STAGE=5/24-bit)
// share one stimulus stream; expected outputs carry the ce-edge index they are due on.
module tb_kernel_fdtd_2d_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic [9:0]  din0 = '0;
  logic [10:0] din1 = '0;
  logic        din_vld = 1'b0;
  logic        din_acc = 1'b0;
  logic [19:0] dout0;
  logic        dout_vld0;
  logic [23:0] dout1;
  logic        dout_vld1;

  int total = 0;
  int bad = 0;
  int ce_cnt = 0;
  bit started = 1'b0;
  logic last_ce = 1'b0;
  logic last_rst = 1'b0;

  logic [23:0] exp_q0[$];
  int          due_q0[$];
  logic [23:0] exp_q1[$];
  int          due_q1[$];
  longint      acc0 = 0;
  longint      acc1 = 0;

  kernel_fdtd_2d_mac_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(10), .din1_WIDTH(11),
                            .dout_WIDTH(20), .SIGNED(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(din_vld), .din_acc(din_acc), .dout(dout0), .dout_vld(dout_vld0));

  kernel_fdtd_2d_mac_pipe #(.ID(2), .NUM_STAGE(5), .din0_WIDTH(10), .din1_WIDTH(11),
                            .dout_WIDTH(24), .SIGNED(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .ce(ce), .din0(din0), .din1(din1),
    .din_vld(din_vld), .din_acc(din_acc), .dout(dout1), .dout_vld(dout_vld1));

  // clock / edge bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    last_ce  <= ce;
    last_rst <= rst_n;
    if (rst_n && ce) ce_cnt <= ce_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired act=running req=finished");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic longint model_prod(logic [9:0] a, logic [10:0] b, bit sgn);
    longint sa = longint'(a);
    longint sb = longint'(b);
    if (sgn && a[9])  sa = sa - 1024;
    if (sgn && b[10]) sb = sb - 2048;
    return sa * sb;
  endfunction

  function automatic longint fit(longint v, int w);
    return v & ((longint'(1) << w) - 1);
  endfunction

  task automatic check(string nm, logic [23:0] act, logic [23:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input bit c, input bit v, input bit ac,
                       input logic [9:0] a, input logic [10:0] b);
    longint f;
    @(posedge clk);
    #1;
    ce = c; din_vld = v; din_acc = ac; din0 = a; din1 = b;
    if (c && v && rst_n) begin
      f = fit(model_prod(a, b, 1'b0), 20);
      acc0 = ac ? fit(acc0 + f, 20) : f;
      exp_q0.push_back(24'(acc0));
      due_q0.push_back(ce_cnt + 1 + 2);
      f = fit(model_prod(a, b, 1'b1), 24);
      acc1 = ac ? fit(acc1 + f, 24) : f;
      exp_q1.push_back(24'(acc1));
      due_q1.push_back(ce_cnt + 1 + 4);
    end
  endtask

  task automatic reset_dut(input bit c);
    @(posedge clk);
    #1;
    rst_n = 1'b0; ce = c; din_vld = 1'b0;
    @(posedge clk);
    #1;
    exp_q0.delete(); due_q0.delete(); exp_q1.delete(); due_q1.delete();
    acc0 = 0; acc1 = 0;
    rst_n = 1'b1; ce = 1'b1; din_vld = 1'b0;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 10'h0, 11'h0);
  endtask

  // monitors: outputs that were due at the last ce edge, held values otherwise
  logic        exp_v0 = 1'b0;
  logic [23:0] mdl_d0 = '0;
  logic        exp_v1 = 1'b0;
  logic [23:0] mdl_d1 = '0;

  always @(negedge clk) begin
    if (started) begin
      if (!last_rst) begin
        exp_v0 = 1'b0; mdl_d0 = '0;
      end else if (last_ce) begin
        exp_v0 = (due_q0.size() > 0) && (due_q0[0] == ce_cnt);
        if (exp_v0) begin
          mdl_d0 = exp_q0.pop_front();
          void'(due_q0.pop_front());
        end
      end
      check("vld0", {23'b0, dout_vld0}, {23'b0, exp_v0});
      check("dout0", {4'b0, dout0}, mdl_d0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (!last_rst) begin
        exp_v1 = 1'b0; mdl_d1 = '0;
      end else if (last_ce) begin
        exp_v1 = (due_q1.size() > 0) && (due_q1[0] == ce_cnt);
        if (exp_v1) begin
          mdl_d1 = exp_q1.pop_front();
          void'(due_q1.pop_front());
        end
      end
      check("vld1", {23'b0, dout_vld1}, {23'b0, exp_v1});
      check("dout1", dout1, mdl_d1);
    end
  end

  // stimulus
  initial begin
    reset_dut(1'b1);
    started = 1'b1;
    bubbles(2);

    // width wrap / full product
    drive(1'b1, 1'b1, 1'b0, 10'd1023, 11'd2047);
    bubbles(6);
    // signed vectors
    drive(1'b1, 1'b1, 1'b0, 10'h200, 11'h7FF);
    drive(1'b1, 1'b1, 1'b0, 10'h3FF, 11'h002);
    bubbles(6);
    // back-to-back accumulate chain, then a bubble
    drive(1'b1, 1'b1, 1'b0, 10'd3, 11'd5);
    drive(1'b1, 1'b1, 1'b1, 10'd7, 11'd2);
    drive(1'b1, 1'b1, 1'b1, 10'd1, 11'd1);
    bubbles(7);
    // stall for 2 cycles after the second of four samples; junk inputs during stall
    drive(1'b1, 1'b1, 1'b0, 10'd11, 11'd13);
    drive(1'b1, 1'b1, 1'b1, 10'd17, 11'd19);
    drive(1'b0, 1'b1, 1'b0, 10'h155, 11'h2AA);
    drive(1'b0, 1'b1, 1'b1, 10'h0AA, 11'h555);
    drive(1'b1, 1'b1, 1'b1, 10'd23, 11'd29);
    drive(1'b1, 1'b1, 1'b0, 10'd31, 11'd37);
    bubbles(2);
    drive(1'b0, 1'b0, 1'b0, 10'h0, 11'h0);
    drive(1'b0, 1'b0, 1'b0, 10'h0, 11'h0);
    bubbles(6);
    // reset mid-flight with ce low; then acc=1 first sample accumulates onto 0
    drive(1'b1, 1'b1, 1'b0, 10'd100, 11'd200);
    drive(1'b1, 1'b1, 1'b0, 10'd300, 11'd400);
    reset_dut(1'b0);
    bubbles(6);
    drive(1'b1, 1'b1, 1'b1, 10'd9, 11'd9);
    bubbles(6);

    // randomized traffic with random stalls and occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_dut(1'($urandom_range(0, 1)));
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 2) != 0,
              1'($urandom_range(0, 1)), 10'($urandom), 11'($urandom));
      end
    end

    bubbles(12);
    check("drain0", 24'(due_q0.size()), 24'd0);
    check("drain1", 24'(due_q1.size()), 24'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kernel_fdtd_2d_mac_pipe.md
# kernel_fdtd_2d_mac_pipe

Parametrised pipelined multiply / multiply-accumulate unit for the fdtd-2d kernel datapath. It generalises the fixed 10x11 unsigned DSP48 multiplier in four ways: configurable operand and result widths, signed or unsigned mode, a configurable pipeline depth, and a valid pipeline so the output has a qualifier. An optional accumulate mode is selected per sample, so successive products can be summed in the output register without an external adder. It drops into the same ce-gated stall scheme used by the other generated operator cores.

## Interface
- ID, 1: instance tag; no functional effect.
- NUM_STAGE, 3: latency from input sample to dout, counted in ce-high clock edges; legal minimum 3.
- din0_WIDTH, 10: operand A width.
- din1_WIDTH, 11: operand B width.
- dout_WIDTH, 20: result/accumulator width.
- SIGNED, 0: 0 = operands unsigned, 1 = operands two's complement.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; a 0 sampled on a clk edge resets the block.
- ce  in  1  clock enable; 0 freezes every register, including reset-free data registers.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- din_vld  in  1  din0/din1/din_acc hold a valid sample.
- din_acc  in  1  1 = add this product to the current dout; 0 = load the product.
- dout  out  dout_WIDTH  result/accumulator register.
- dout_vld  out  1  one-cycle pulse when dout is updated by a sample.

## Operation
- Pipeline structure:
  - Stage 1 registers din0, din1, din_vld and din_acc.
  - Stages 2 to NUM_STAGE-1 carry the full-width product plus the vld/acc sideband. There are NUM_STAGE-2 product stages, which gives retiming room for DSP inference.
  - Stage NUM_STAGE is the dout register.
- Product width is din0_WIDTH+din1_WIDTH.
  - SIGNED=1: operands are sign-extended and the product is signed.
  - SIGNED=0: zero-extended, unsigned product.
- Result fit:
  - If dout_WIDTH is less than the product width, keep the low dout_WIDTH bits (wrap, no saturation).
  - If dout_WIDTH is greater, extend the product: sign-extend when SIGNED=1, zero-extend when SIGNED=0.
- Output stage, on a ce-high edge:
  - vld=1, acc=0: dout <= fitted product.
  - vld=1, acc=1: dout <= dout + fitted product, modulo 2^dout_WIDTH; overflow wraps silently.
  - vld=0: dout holds.
  - dout_vld <= the stage vld bit.
- Invalid samples (din_vld=0) move through the pipeline as bubbles. Their data is don't-care and must never alter dout.
- Accumulate chain: the first sample of a chain must have din_acc=0. A sample with acc=1 arriving after reset accumulates onto 0.
- Reset: every vld bit, the acc sideband, dout and dout_vld are cleared to 0; data registers are cleared to 0. Samples in flight are discarded and produce no dout_vld.
- Reset takes priority over ce: reset=0 clears state even when ce=0.

## Timing
- Sample presented with din_vld=1 before ce-high edge k appears on dout with dout_vld=1 after ce-high edge k+NUM_STAGE-1. This is NUM_STAGE ce-high edges in total, counting edge k.
- Throughput: one sample per ce-high cycle; no internal backpressure.
- ce=0 cycles add to latency one-for-one. While ce=0, dout and dout_vld hold their values: a dout_vld that was 1 stays 1 through the stall. Consumers must qualify with ce or use it as a stall signal, as elsewhere in the design.
- Back-to-back acc=1 samples accumulate every cycle. The accumulator adder must close timing in a single stage.
- Reset values after deassertion: dout=0, dout_vld=0. The first valid output can appear NUM_STAGE ce-high edges after the first sample.

## Test plan
- Unsigned width wrap (defaults): din0=1023, din1=2047, din_acc=0, vld 1 cycle, ce=1 -> after 3 edges dout=0xFF401 (full product 0x1FF401 truncated), dout_vld high for exactly 1 cycle.
- Signed mode (SIGNED=1, defaults otherwise): din0=10'h200 (-512), din1=11'h7FF (-1) -> dout=0x00200. Then din0=10'h3FF (-1), din1=11'h002 -> dout=0xFFFFE.
- Accumulate chain, back to back: (3,5,acc0), (7,2,acc1), (1,1,acc1) -> dout sequence 15, 29, 30 on three consecutive dout_vld pulses. A following bubble leaves dout at 30.
- Stall: stream 4 samples, drop ce for 2 cycles after the second -> outputs are identical to the unstalled case, each delayed by 2 cycles; dout and dout_vld are frozen during the stall.
- Reset mid-flight: 2 valid samples in the pipe, reset=0 for 1 edge with ce=0 -> dout=0, dout_vld=0, and neither sample ever produces dout_vld.
- NUM_STAGE=5, dout_WIDTH=24: din0=1023, din1=2047 -> dout=0x1FF401 exactly 5 edges after the input.
